// File: rtl/demux_serializer_if.sv
// Word-in / serial-out bundle between an upstream word source and demux_serializer.
interface demux_serializer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_dest;
  logic [1:0]       sel;
  logic             d;
  logic             frame;
  logic             done;

  modport master (
    output in_valid, in_data, in_dest,
    input  in_ready, sel, d, frame, done
  );

  modport slave (
    input  in_valid, in_data, in_dest,
    output in_ready, sel, d, frame, done
  );
endinterface

// File: rtl/demux_serializer.sv
// Serialises accepted words LSB-first onto the 1:4 demux data bit, holding the
// destination on sel for the whole frame and forcing d low between frames.
module demux_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic           clk,
  input  logic           rst,
  demux_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT   = CW'(WIDTH - 2);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bitcnt;
  logic [3:0]       gapcnt;

  // bit 0 of shreg is already on d by the time it would be read
  logic unused_lsb;
  assign unused_lsb = shreg[0];

  assign bus.in_ready = (state == ST_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      gapcnt    <= '0;
      bus.sel   <= '0;
      bus.d     <= 1'b0;
      bus.frame <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            shreg     <= bus.in_data;
            bus.sel   <= bus.in_dest;
            bitcnt    <= '0;
            bus.frame <= 1'b1;
            bus.d     <= bus.in_data[0];
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bitcnt == LAST) begin
            bus.frame <= 1'b0;
            bus.d     <= 1'b0;
            bus.done  <= 1'b0;
            gapcnt    <= '0;
            state     <= (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            // done is registered, so it is raised on the edge that loads the last bit
            shreg    <= shreg >> 1;
            bus.d    <= shreg[1];
            bitcnt   <= bitcnt + 1'b1;
            bus.done <= (bitcnt == PENULT);
          end
        end
        ST_GAP: begin
          if (gapcnt == GAP_LAST) begin
            gapcnt <= '0;
            state  <= ST_IDLE;
          end else begin
            gapcnt <= gapcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_demux_serializer.sv
// Scoreboard bench: the driver queues per-cycle expected bits at each accept,
// a negedge monitor compares them and the idle/ready behaviour of the block.
module tb_demux_serializer;
  localparam int W = 8;
  localparam int G = 1;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  sel;
    logic        d;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  logic rst_q = 1'b0;
  int unsigned cyc = 0;
  int unsigned ready_at = 0;
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int exp_done = 0;
  bit checking = 0;
  logic [1:0] hold_sel = '0;
  exp_t sbq[$];

  // second instance: 4-bit words, no gap
  logic [3:0] words2 [2];
  int unsigned acc2 [2];
  logic bits2[$];
  int gap2 = 0;
  int done2 = 0;
  bit fin2 = 0;

  demux_serializer_if #(.WIDTH(W)) bus ();
  demux_serializer_if #(.WIDTH(4)) bus2 ();

  demux_serializer #(.WIDTH(W), .GAP(G)) dut (.clk(clk), .rst(rst), .bus(bus));
  demux_serializer #(.WIDTH(4), .GAP(0)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_q === 1'b1) begin
      checking = 1;
      hold_sel = '0;
      check("rst_sel", 32'(bus.sel), 0);
      check("rst_d", 32'(bus.d), 0);
      check("rst_frame", 32'(bus.frame), 0);
      check("rst_done", 32'(bus.done), 0);
    end else if (checking) begin
      if (bus.frame === 1'b1) begin
        if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
          check("frame_unexpected", 32'(bus.frame), 0);
        end else begin
          e = sbq.pop_front();
          check("bit_d", 32'(bus.d), 32'(e.d));
          check("bit_sel", 32'(bus.sel), 32'(e.sel));
          check("bit_done", 32'(bus.done), 32'(e.done));
          hold_sel = e.sel;
        end
      end else begin
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
          check("frame_missing", 32'(bus.frame), 1);
          void'(sbq.pop_front());
        end
        check("idle_d", 32'(bus.d), 0);
        check("idle_done", 32'(bus.done), 0);
        check("idle_sel", 32'(bus.sel), 32'(hold_sel));
      end
      if (bus.done === 1'b1) done_seen++;
    end
    if (checking) check("in_ready", 32'(bus.in_ready), 32'(!rst && cyc >= ready_at));
    if (rst) begin
      sbq.delete();
      ready_at = cyc + 1;
    end
  end

  task automatic send(input logic [7:0] data, input logic [1:0] dest, input bit keep,
                      output int unsigned acc);
    bit got = 0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_dest  = dest;
    acc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      #1;
      if (bus.in_ready === 1'b1) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 40 cycles (cycle %0d)", cyc);
    end else begin
      acc = cyc;
      for (int i = 0; i < W; i++) begin
        e.cyc  = cyc + 1 + i;
        e.sel  = dest;
        e.d    = data[i];
        e.done = (i == W - 1);
        sbq.push_back(e);
      end
      ready_at = cyc + W + G + 1;
      exp_done++;
    end
    @(posedge clk);
    #1;
    bus.in_data = 8'($urandom);
    bus.in_dest = 2'($urandom);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int unsigned a1, a2;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    bus.in_dest  = 2'd3;
    idle(2);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    idle(2);

    send(8'hA5, 2'd2, 0, a1);
    idle(12);

    send(8'h0F, 2'd0, 1, a1);
    send(8'hF0, 2'd3, 0, a2);
    check("b2b_interval", a2 - a1, W + G + 1);
    idle(12);

    send(8'hFF, 2'd1, 0, a1);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_done--;
    send(8'h01, 2'd1, 0, a1);
    idle(10);

    for (int dst = 0; dst < 4; dst++) begin
      send(8'h80, 2'(dst), 0, a1);
      idle($urandom_range(0, 2));
    end

    for (int n = 0; n < 40; n++) begin
      bit keep;
      keep = 1'($urandom_range(0, 1));
      send(8'($urandom), 2'($urandom), keep, a1);
      if (!keep) idle($urandom_range(0, 3));
    end
    bus.in_valid = 1'b0;

    for (int i = 0; i < 40 && sbq.size() > 0; i++) @(negedge clk);
    check("drain_left", sbq.size(), 0);
    idle(3);
    check("done_count", done_seen, exp_done);

    check("g0_finished", 32'(fin2), 1);
    check("g0_interval", acc2[1] - acc2[0], 5);
    check("g0_gap", gap2, 1);
    check("g0_nbits", bits2.size(), 8);
    check("g0_done", done2, 2);
    for (int i = 0; i < 8 && i < bits2.size(); i++) begin
      logic [3:0] w;
      w = words2[i / 4];
      check("g0_bit", 32'(bits2[i]), 32'(w[i % 4]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    bit got;
    words2[0] = 4'h9;
    words2[1] = 4'h6;
    acc2[0] = 0;
    acc2[1] = 0;
    rst2 = 1'b1;
    bus2.in_valid = 1'b0;
    bus2.in_data  = '0;
    bus2.in_dest  = '0;
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0;
    for (int w = 0; w < 2; w++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = words2[w];
      bus2.in_dest  = 2'(w + 1);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        #1;
        if (bus2.in_ready === 1'b1) got = 1;
      end
      if (got) acc2[w] = cyc;
      @(posedge clk);
      #1;
    end
    bus2.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    fin2 = 1;
  end

  always @(negedge clk) begin
    if (rst2 === 1'b0) begin
      if (bus2.frame === 1'b1) bits2.push_back(bus2.d);
      else if (bits2.size() == 4) gap2++;
      if (bus2.done === 1'b1) done2++;
    end
  end
endmodule

// File: doc/demux_serializer.md
# demux_serializer

Upstream feeder for the 1:4 demultiplexer. Accepts parallel words with a 2-bit destination over a valid/ready handshake, then serialises each word LSB-first onto the demux data bit. The destination is held on the demux select for the whole frame. Between frames the data bit is forced low, so all four demux outputs idle at 0.

## Interface

**Parameters**
- `WIDTH`, default 8: bits per word; legal range 2..32.
- `GAP`, default 1: idle cycles inserted after each frame; legal range 0..15.

**Ports**
- `clk`  in  1  clock. One clock domain; all logic is rising-edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  upstream word available.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  WIDTH  word to serialise.
- `in_dest`  in  2  target demux output (0..3).
- `sel`  out  2  demux select, registered.
- `d`  out  1  demux data bit, registered.
- `frame`  out  1  high while `d` carries a valid word bit, registered.
- `done`  out  1  one-cycle pulse coincident with the last bit of a frame, registered.

## Operation

**States:** IDLE, SHIFT, GAP.

**IDLE**
- `in_ready` = 1 and `frame` = 0; `d` = 0; `sel` holds its previous value.
- A transfer occurs when `in_valid` and `in_ready` are both high at a rising edge. On that edge:
  - `shreg` ← `in_data`
  - `sel` ← `in_dest`
  - bit counter ← 0
  - `frame` ← 1, `d` ← `in_data[0]`
  - next state SHIFT.

**SHIFT**
- `in_ready` = 0.
- Each edge: `shreg` shifts right by 1, `d` ← next bit, counter increments.
- The cycle presenting bit WIDTH-1 has `done` = 1.
- Leaving on the edge that ends that cycle:
  - go to GAP if `GAP` > 0, otherwise IDLE;
  - `frame` ← 0, `d` ← 0.

**GAP**
- `in_ready` = 0, `frame` = 0, `d` = 0; `sel` is held.
- Lasts exactly `GAP` cycles, counted by a 4-bit counter, then returns to IDLE.

**General rules**
- `in_ready` is combinational: (state == IDLE) && !`rst`.
- `in_data` and `in_dest` are sampled only at the accepting edge. Changes during SHIFT or GAP are ignored.
- `in_valid` low in IDLE: the block stays in IDLE and all outputs hold.
- Invariant: `d` = 0 whenever `frame` = 0.
- The bit counter width is clog2(WIDTH). The counter never wraps past WIDTH-1.

**Reset**
- `rst` high at an edge forces: state IDLE, `sel` = 0, `d` = 0, `frame` = 0, `done` = 0, `shreg` = 0, both counters = 0.
- `in_ready` is 0 while `rst` is high.
- Reset mid-frame aborts the frame. Remaining bits are discarded and no `done` is produced.

## Timing

Let the accepting edge end cycle k.
- Cycles k+1 .. k+WIDTH:
  - `frame` = 1 and `sel` = the accepted `in_dest`;
  - in cycle k+i, `d` = `in_data[i-1]`.
- `done` = 1 in cycle k+WIDTH only.
- Cycles k+WIDTH+1 .. k+WIDTH+GAP: GAP state.
- `in_ready` returns high in cycle k+WIDTH+GAP+1.
- Minimum word period is WIDTH+GAP+1 cycles. With `GAP` = 0 one IDLE cycle still separates frames.
- Latency from accept to the first bit on `d` is 1 cycle.
- `sel` changes only at accepting edges or at reset, never while `frame` = 1.

## Test plan

1. **Reset values.** Hold `rst` for 2 cycles with `in_valid` = 1.
   - `sel` = 0, `d` = 0, `frame` = 0, `done` = 0, `in_ready` = 0 throughout.
   - `in_ready` = 1 in the first cycle after `rst` falls.
2. **Single word.** WIDTH = 8, GAP = 1; send `in_data` = 0xA5 with `in_dest` = 2.
   - `d` = 1,0,1,0,0,1,0,1 over 8 cycles, with `frame` = 1 and `sel` = 2.
   - `done` high on the 8th bit only.
   - 1 GAP cycle, then `in_ready` = 1 at cycle k+10.
3. **Back-to-back.** Hold `in_valid` high; present 0x0F (dest 0), then 0xF0 (dest 3).
   - The second word is accepted exactly 10 cycles after the first.
   - `sel` goes 0 → 3 only at the second accept; `d` is 0 in the gap.
4. **GAP = 0.** WIDTH = 4; continuous `in_valid` with 0x9, then 0x6.
   - Word period is 5 cycles; bit streams are 1,0,0,1 and 0,1,1,0.
   - Exactly one `frame` = 0 cycle separates the two frames.
5. **Reset mid-frame.** Accept 0xFF, then assert `rst` after the 3rd bit.
   - Next cycle shows reset values; no `done` pulse.
   - A new word 0x01 (dest 1) after reset serialises correctly with `sel` = 1.
6. **Destination sweep.** Send 0x80 to dest 0..3 in turn.
   - `sel` matches each dest for the full frame.
   - `d` = 1 only on the 8th bit of each frame.
   - `done` count = 4.
